fc_operand_feeder: RTL
======================

Name: fc_operand_feeder

Overview:
- Transmitter side of the fully-connected neuron operand interface.
- Accepts pooled pixels one byte per beat over valid/ready and packs 8 beats into the 8x8-bit pooled pixel array.
- Holds that array stable, steps the neuron's 64-bit weight word through NUM_NEURONS stored weight vectors, and captures each registered neuron result.
- Streams each captured result out with its index; optionally reports the argmax class. Sits between the pooling stage and the FC neuron.

Parameters:
- NUM_NEURONS, 10, number of weight vectors and results per frame (2..256).
- IDX_W, $clog2(NUM_NEURONS), width of neuron index fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset
- pix_valid  in  1  pooled pixel beat valid
- pix_data  in  8  pooled pixel byte
- pix_ready  out  1  feeder accepts a pixel beat
- wgt_we  in  1  weight store write enable
- wgt_addr  in  IDX_W  weight vector index
- wgt_wdata  in  64  weight vector; byte j multiplies pixel j
- pooled_pixel_array  out  [7:0][7:0]  to neuron pixel input
- weight  out  64  to neuron weight input
- neuron_result  in  8  registered neuron output
- res_valid  out  1  result beat valid, one cycle
- res_idx  out  IDX_W  neuron index of res_data
- res_data  out  8  captured neuron result
- frame_done  out  1  one-cycle pulse with the last res_valid of a frame
- class_valid  out  1  argmax valid, one cycle (ARGMAX_EN)
- class_idx  out  IDX_W  argmax index (ARGMAX_EN)

Interface (already decided): one clock, clk; reset is rst_n, asynchronous, active-low.

Behaviour:
- Reset (async assert, sync deassert use): state=COLLECT, counters 0, pooled_pixel_array=0, weight=0, weight store=0, all valids/pulses 0, res_idx/res_data/class_idx=0.
- FSM states: COLLECT, ISSUE, DRAIN.
- COLLECT:
  - pix_ready=1; a beat is accepted on pix_valid&&pix_ready.
  - Beat n (0..7) is written to pooled_pixel_array[n]; the first byte goes to [0].
  - Accepting beat 7 moves the FSM to ISSUE with k=0.
- ISSUE:
  - pix_ready=0.
  - weight=store[k] in the k-th ISSUE cycle; k increments every cycle.
  - After k=NUM_NEURONS-1 the FSM moves to DRAIN.
- DRAIN: one cycle, pix_ready=0, weight holds its last value, then the FSM returns to COLLECT.
- pooled_pixel_array is constant from the ISSUE entry until the first new beat is accepted.
- Neuron latency is 1 cycle: result k is present on neuron_result in ISSUE cycle k+1 (cycle k+1 is DRAIN for the last k).
- The feeder registers result k; res_valid=1, res_idx=k, res_data=result k during cycle ISSUE_start+k+2.
- Frame timing: the last result beat lands in the first COLLECT cycle, where frame_done=1. Frame turnaround is 8 beats + NUM_NEURONS + 1 cycles.
- A pixel beat can be accepted in the same cycle as the last res_valid.
- Weight store:
  - Writable in any state; a write takes effect at the clock edge.
  - A read of the same index in the same cycle returns the old value.
  - wgt_addr>=NUM_NEURONS is ignored.
- Arithmetic: none in the feeder. res_data is the neuron's 8-bit modulo-256 result, passed unchanged.
- pix_valid while pix_ready=0 is not consumed; the source must hold data.
- rst_n assertion mid-frame aborts the frame; no res_valid or frame_done follows.

Optional Feature:
- Macro: ARGMAX_EN.
- Defined:
  - A running max of res_data (unsigned) is tracked per frame; ties keep the lower index.
  - class_valid=1 and class_idx=winner in the frame_done cycle.
  - The tracker resets at the first result beat of each frame.
- Undefined: class_valid and class_idx tied to 0, no tracker logic.

Decomposition:
- Package fc_pkg:
  - PIX_PER_VEC=8, PIX_W=8, WGT_W=64.
  - feeder_state_e enum {COLLECT, ISSUE, DRAIN}.
  - pixel_vec_t typedef [7:0][7:0].
- Sub-module fc_weight_store: NUM_NEURONS x 64 register file, async read, sync write, async clear.

Test Plan:
- Pixels 1..8, all weights 0x0101010101010101, NUM_NEURONS=10 -> ten res_valid beats idx 0..9, each res_data=36; frame_done with idx 9.
- Weight vector 3 = 0x0202020202020202, others 0x01 bytes, pixels 1..8 -> idx 3 gives 72, others 36; ARGMAX_EN gives class_idx=3.
- Pixels all 0xFF, weight 0x0101010101010101 -> res_data=0xF8 (2040 mod 256) for every idx.
- pix_valid held high during ISSUE/DRAIN -> pix_ready=0, no beat consumed; the next frame starts only after DRAIN.
- Rewrite of store[5] during ISSUE k=5 -> that frame uses the old vector; the next frame uses the new one.
- rst_n pulsed low at ISSUE k=4 -> outputs cleared immediately, no frame_done; a new 8-beat frame then completes normally with weights all zero (res_data=0).

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and widths for the FC operand feeder and its weight store.
package fc_pkg;

  localparam int PIX_PER_VEC = 8;
  localparam int PIX_W       = 8;
  localparam int WGT_W       = 64;

  typedef enum logic [1:0] {
    COLLECT,
    ISSUE,
    DRAIN
  } feeder_state_e;

  typedef logic [PIX_PER_VEC-1:0][PIX_W-1:0] pixel_vec_t;

endpackage

// File: rtl/fc_weight_store.sv
// NUM_NEURONS x 64-bit weight register file: sync write, async read, async clear.
// Out-of-range write addresses are dropped; out-of-range reads return zero.
module fc_weight_store
  import fc_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WGT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WGT_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_NEURONS);

  logic [WGT_W-1:0] mem [NUM_NEURONS];
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH);
  assign raddr_ok = ({1'b0, raddr} < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/fc_operand_feeder.sv
// Packs 8 pooled pixel beats, steps the neuron weight through the store and streams results.
// Optional argmax reporting is enabled by defining ARGMAX_EN.
//
// state   | meaning
// COLLECT | accept pixel beats into the array, pix_ready=1
// ISSUE   | present store[k] on weight, k = 0..NUM_NEURONS-1
// DRAIN   | one cycle for the last neuron result to arrive
module fc_operand_feeder
  import fc_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             wgt_we,
  input  logic [IDX_W-1:0] wgt_addr,
  input  logic [WGT_W-1:0] wgt_wdata,
  output pixel_vec_t       pooled_pixel_array,
  output logic [WGT_W-1:0] weight,
  input  logic [PIX_W-1:0] neuron_result,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic [PIX_W-1:0] res_data,
  output logic             frame_done,
  output logic             class_valid,
  output logic [IDX_W-1:0] class_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  feeder_state_e    state;
  feeder_state_e    state_nxt;
  logic [2:0]       beat_cnt;
  logic [IDX_W-1:0] k_cnt;
  logic             accept;
  logic             last_beat;
  logic             issue_last;
  logic             capture;
  logic [IDX_W-1:0] cap_idx;
  logic [IDX_W-1:0] rd_addr;
  logic [WGT_W-1:0] rd_data;

  fc_weight_store #(
    .NUM_NEURONS(NUM_NEURONS),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wgt_we),
    .waddr(wgt_addr),
    .wdata(wgt_wdata),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign accept     = pix_valid && pix_ready;
  assign last_beat  = accept && (beat_cnt == 3'd7);
  assign issue_last = (state == ISSUE) && (k_cnt == LAST_IDX);
  // Result k arrives one cycle after weight k, so the capture index lags k by one.
  assign capture    = ((state == ISSUE) && (k_cnt != '0)) || (state == DRAIN);
  assign cap_idx    = (state == DRAIN) ? LAST_IDX : (k_cnt - IDX_W'(1));
  // weight is registered, so the store is read one entry ahead of the presented index.
  assign rd_addr    = (state == ISSUE) ? (k_cnt + IDX_W'(1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last_beat)  state_nxt = ISSUE;
      ISSUE:   if (issue_last) state_nxt = DRAIN;
      DRAIN:                   state_nxt = COLLECT;
      default:                 state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    pix_ready = (state == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt           <= '0;
      k_cnt              <= '0;
      pooled_pixel_array <= '0;
      weight             <= '0;
    end else begin
      if (accept) begin
        beat_cnt                     <= beat_cnt + 3'd1;
        pooled_pixel_array[beat_cnt] <= pix_data;
      end
      if (state == ISSUE) k_cnt <= issue_last ? '0 : (k_cnt + IDX_W'(1));
      else                k_cnt <= '0;
      if (last_beat || ((state == ISSUE) && !issue_last)) weight <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      res_valid  <= capture;
      frame_done <= (state == DRAIN);
      if (capture) begin
        res_idx  <= cap_idx;
        res_data <= neuron_result;
      end
    end
  end

`ifdef ARGMAX_EN
  logic [PIX_W-1:0] max_val;
  logic [PIX_W-1:0] max_val_nxt;
  logic [IDX_W-1:0] max_idx;
  logic [IDX_W-1:0] max_idx_nxt;

  // Strict compare keeps the lower index on ties; index 0 restarts the tracker.
  always_comb begin
    max_val_nxt = max_val;
    max_idx_nxt = max_idx;
    if (capture && ((cap_idx == '0) || (neuron_result > max_val))) begin
      max_val_nxt = neuron_result;
      max_idx_nxt = cap_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val     <= '0;
      max_idx     <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
    end else begin
      max_val     <= max_val_nxt;
      max_idx     <= max_idx_nxt;
      class_valid <= (state == DRAIN);
      if (state == DRAIN) class_idx <= max_idx_nxt;
    end
  end
`else
  assign class_valid = 1'b0;
  assign class_idx   = '0;
`endif

endmodule
